// File: rtl/pwm_deadtime_out.sv
// Complementary high/low gate drive per PWM channel with programmable dead band and latched fault.
// Define PWM_DT_GLITCH_FILTER_EN to insert a per-channel input stability filter.
module pwm_deadtime_out #(
    parameter int NCH           = 8,
    parameter int DTW           = 8,
    parameter int GLITCH_CYCLES = 2
) (
    input  logic           HCLK,
    input  logic           HRESETn,
    input  logic [NCH-1:0] pwm_in,
    input  logic           enable,
    input  logic [DTW-1:0] dead_cycles,
    input  logic           fault_n,
    input  logic           fault_clr,
    output logic [NCH-1:0] pwm_hi,
    output logic [NCH-1:0] pwm_lo,
    output logic           fault_latched,
    output logic [NCH-1:0] busy
);

    typedef enum logic [1:0] {S_OFF, S_DEAD, S_HI, S_LO} state_t;

    state_t         state_q [NCH];
    state_t         state_d [NCH];
    logic [DTW-1:0] cnt_q   [NCH];
    logic [DTW-1:0] cnt_d   [NCH];
    logic [NCH-1:0] target_q;
    logic [NCH-1:0] target_d;
    logic [NCH-1:0] in_q;
    logic [NCH-1:0] lvl;
    logic [NCH-1:0] enter;
    logic [DTW-1:0] reload;
    logic           dead_zero;
    logic           force_off;
    logic           fault_d;

    if (GLITCH_CYCLES < 1) begin : g_bad_cfg
        $error("GLITCH_CYCLES must be at least 1");
    end

`ifdef PWM_DT_GLITCH_FILTER_EN
    localparam int GW = $clog2(GLITCH_CYCLES + 1);

    logic [GW-1:0]  gcnt_q [NCH];
    logic [NCH-1:0] filt_q;

    // A new level reaches the FSM only after it has been stable for GLITCH_CYCLES samples.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            filt_q <= '0;
            for (int i = 0; i < NCH; i++) gcnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (in_q[i] == filt_q[i]) begin
                    gcnt_q[i] <= '0;
                end else if (gcnt_q[i] == GW'(GLITCH_CYCLES - 1)) begin
                    filt_q[i] <= in_q[i];
                    gcnt_q[i] <= '0;
                end else begin
                    gcnt_q[i] <= gcnt_q[i] + GW'(1);
                end
            end
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = in_q;
`endif

    assign reload    = dead_cycles - DTW'(1);
    assign dead_zero = (dead_cycles == '0);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch can be inferred.
        force_off = !enable || !fault_n || fault_latched;
        fault_d   = fault_latched;
        if (!fault_n) begin
            fault_d = 1'b1;
        end else if (fault_clr) begin
            fault_d = 1'b0;
        end

        for (int i = 0; i < NCH; i++) begin
            state_d[i]  = state_q[i];
            cnt_d[i]    = cnt_q[i];
            target_d[i] = target_q[i];
            enter[i]    = 1'b0;

            case (state_q[i])
                S_OFF:  enter[i] = 1'b1;
                S_DEAD: begin
                    if (lvl[i] != target_q[i]) begin
                        enter[i] = 1'b1;
                    end else if (cnt_q[i] == '0) begin
                        state_d[i] = target_q[i] ? S_HI : S_LO;
                    end else begin
                        cnt_d[i] = cnt_q[i] - DTW'(1);
                    end
                end
                S_HI:    enter[i] = !lvl[i];
                S_LO:    enter[i] = lvl[i];
                default: state_d[i] = S_OFF;
            endcase

            // A zero dead band swaps sides in one edge; outputs come from one state, so never overlap.
            if (enter[i]) begin
                target_d[i] = lvl[i];
                if (dead_zero) begin
                    state_d[i] = lvl[i] ? S_HI : S_LO;
                end else begin
                    state_d[i] = S_DEAD;
                    cnt_d[i]   = reload;
                end
            end

            if (force_off) state_d[i] = S_OFF;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            in_q          <= '0;
            target_q      <= '0;
            fault_latched <= 1'b0;
            pwm_hi        <= '0;
            pwm_lo        <= '0;
            busy          <= '0;
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= S_OFF;
                cnt_q[i]   <= '0;
            end
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments only.
            in_q          <= pwm_in;
            target_q      <= target_d;
            fault_latched <= fault_d;
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                pwm_hi[i]  <= (state_d[i] == S_HI);
                pwm_lo[i]  <= (state_d[i] == S_LO);
                busy[i]    <= (state_d[i] == S_DEAD);
            end
        end
    end

endmodule

// File: tb/tb_pwm_deadtime_out.sv
// Self-checking bench for pwm_deadtime_out: directed vector table, corner-case sequences,
// and randomized stimulus against a timestamp-based reference model.
module tb_pwm_deadtime_out;

    logic       HCLK = 1'b0;
    logic       HRESETn = 1'b1;
    logic [7:0] pwm_in = '0;
    logic       enable = 1'b0;
    logic [7:0] dead_cycles = 8'd4;
    logic       fault_n = 1'b1;
    logic       fault_clr = 1'b0;
    logic [7:0] pwm_hi;
    logic [7:0] pwm_lo;
    logic [7:0] busy;
    logic       fault_latched;

    int n_tests = 0;
    int n_fail  = 0;
    bit mchk    = 1'b0;

    always #5 HCLK = ~HCLK;

    pwm_deadtime_out dut (
        .HCLK          (HCLK),
        .HRESETn       (HRESETn),
        .pwm_in        (pwm_in),
        .enable        (enable),
        .dead_cycles   (dead_cycles),
        .fault_n       (fault_n),
        .fault_clr     (fault_clr),
        .pwm_hi        (pwm_hi),
        .pwm_lo        (pwm_lo),
        .fault_latched (fault_latched),
        .busy          (busy)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] obs();
        return {7'b0, pwm_hi, pwm_lo, busy, fault_latched};
    endfunction

    // Reference model: each channel is either inactive or driving a target side from a
    // deadline timestamp onward; any change of the sampled level restarts the deadline.
    int       m_k = 0;
    bit [7:0] m_inq = '0;
    bit [7:0] m_act = '0;
    bit [7:0] m_tgt = '0;
    int       m_dl [8];
    bit       m_fl = 1'b0;
    bit       m_force;

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            m_k = 0; m_inq = '0; m_act = '0; m_tgt = '0; m_fl = 1'b0;
            for (int i = 0; i < 8; i++) m_dl[i] = 0;
        end else begin
            m_k++;
            m_force = !enable || !fault_n || m_fl;
            for (int i = 0; i < 8; i++) begin
                if (m_force) begin
                    m_act[i] = 1'b0;
                end else if (!m_act[i] || m_inq[i] != m_tgt[i]) begin
                    m_act[i] = 1'b1;
                    m_tgt[i] = m_inq[i];
                    m_dl[i]  = m_k + int'(dead_cycles);
                end
            end
            m_inq = pwm_in;
            if (!fault_n) m_fl = 1'b1;
            else if (fault_clr) m_fl = 1'b0;
        end
    end

    function automatic logic [31:0] model_obs();
        logic [7:0] h, l, b;
        for (int i = 0; i < 8; i++) begin
            h[i] = m_act[i] && (m_k >= m_dl[i]) && m_tgt[i];
            l[i] = m_act[i] && (m_k >= m_dl[i]) && !m_tgt[i];
            b[i] = m_act[i] && (m_k < m_dl[i]);
        end
        return {7'b0, h, l, b, m_fl};
    endfunction

    always @(negedge HCLK) begin
        if (mchk) begin
            check("model", obs(), model_obs());
            check("no_overlap", {24'b0, pwm_hi & pwm_lo}, 32'h0);
        end
    end

    typedef struct {
        logic [7:0] pwm;
        logic       en;
        logic [7:0] hi;
        logic [7:0] lo;
        logic [7:0] bsy;
    } vec_t;

    vec_t tbl [12];

    int  first_hi;
    int  lo1_seen;
    int  busy3_seen;

    initial begin
        // Channel 0 rise with a 4-cycle dead band, starting from reset with all channels low.
        for (int r = 0; r < 4; r++) tbl[r] = '{8'h00, 1'b1, 8'h00, 8'h00, 8'hFF};
        tbl[4]  = '{8'h00, 1'b1, 8'h00, 8'hFF, 8'h00};
        tbl[5]  = '{8'h01, 1'b1, 8'h00, 8'hFF, 8'h00};
        for (int r = 6; r < 10; r++) tbl[r] = '{8'h01, 1'b1, 8'h00, 8'hFE, 8'h01};
        tbl[10] = '{8'h01, 1'b1, 8'h01, 8'hFE, 8'h00};
        tbl[11] = '{8'h01, 1'b1, 8'h01, 8'hFE, 8'h00};

        #1 HRESETn = 1'b0;
        repeat (3) @(negedge HCLK);
        check("reset_state", obs(), 32'h0);
        HRESETn = 1'b1;
        mchk = 1'b1;

        for (int r = 0; r < 12; r++) begin
            pwm_in = tbl[r].pwm;
            enable = tbl[r].en;
            @(negedge HCLK);
            check($sformatf("vec%0d", r), obs(), {7'b0, tbl[r].hi, tbl[r].lo, tbl[r].bsy, 1'b0});
        end

        // Dead band restart on channel 1 with D=6.
        dead_cycles = 8'd6;
        pwm_in = 8'h03;
        repeat (10) @(negedge HCLK);
        check("ch1_hi_before", {31'b0, pwm_hi[1]}, 32'h1);
        pwm_in = 8'h01;
        @(negedge HCLK);
        check("ch1_hi_held_one_edge", {31'b0, pwm_hi[1]}, 32'h1);
        @(negedge HCLK);
        check("ch1_dead", {30'b0, pwm_hi[1], busy[1]}, 32'h1);
        pwm_in = 8'h03;
        first_hi = -1;
        lo1_seen = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge HCLK);
            if (pwm_lo[1]) lo1_seen++;
            if (pwm_hi[1] && first_hi < 0) first_hi = i;
        end
        check("restart_lo1_quiet", lo1_seen, 0);
        check("restart_hi1_delay", first_hi, 7);

        // Zero dead band: direct swaps on channel 3, never in DEAD.
        dead_cycles = 8'd0;
        busy3_seen = 0;
        for (int t = 0; t < 24; t++) begin
            if (t % 3 == 0) pwm_in[3] = ~pwm_in[3];
            @(negedge HCLK);
            if (busy[3]) busy3_seen++;
        end
        repeat (2) @(negedge HCLK);
        check("d0_busy3_never", busy3_seen, 0);
        check("d0_hi3_follows", {30'b0, pwm_hi[3], pwm_lo[3]}, {30'b0, pwm_in[3], ~pwm_in[3]});

        // Latched fault, ignored clear during fault, resume through a full dead band.
        dead_cycles = 8'd3;
        pwm_in = 8'hA5;
        repeat (8) @(negedge HCLK);
        check("steady_a5", obs(), {7'b0, 8'hA5, 8'h5A, 8'h00, 1'b0});
        fault_n = 1'b0;
        @(negedge HCLK);
        check("fault_shutdown", obs(), 32'h1);
        fault_n = 1'b1;
        repeat (3) @(negedge HCLK);
        check("fault_sticky", obs(), 32'h1);
        fault_n = 1'b0;
        fault_clr = 1'b1;
        @(negedge HCLK);
        check("clr_ignored_in_fault", obs(), 32'h1);
        fault_n = 1'b1;
        fault_clr = 1'b0;
        @(negedge HCLK);
        check("still_latched", obs(), 32'h1);
        fault_clr = 1'b1;
        @(negedge HCLK);
        check("fault_cleared", obs(), 32'h0);
        fault_clr = 1'b0;
        @(negedge HCLK);
        check("resume_dead", obs(), {7'b0, 8'h00, 8'h00, 8'hFF, 1'b0});
        repeat (2) @(negedge HCLK);
        check("resume_dead_end", obs(), {7'b0, 8'h00, 8'h00, 8'hFF, 1'b0});
        @(negedge HCLK);
        check("resumed", obs(), {7'b0, 8'hA5, 8'h5A, 8'h00, 1'b0});

        // Asynchronous reset in the middle of a dead band.
        dead_cycles = 8'd5;
        pwm_in = 8'h5A;
        repeat (2) @(negedge HCLK);
        check("pre_reset_dead", {24'b0, busy}, 32'hFF);
        @(posedge HCLK);
        #2 HRESETn = 1'b0;
        enable = 1'b0;
        #1 check("async_reset", obs(), 32'h0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (4) @(negedge HCLK);
        check("off_until_enable", obs(), 32'h0);
        enable = 1'b1;
        @(negedge HCLK);
        check("enable_enters_dead", obs(), {7'b0, 8'h00, 8'h00, 8'hFF, 1'b0});

        // Randomized traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(3) == 0) pwm_in = 8'($urandom);
            if ($urandom_range(15) == 0) dead_cycles = 8'($urandom_range(7));
            enable    = ($urandom_range(63) != 0);
            fault_n   = ($urandom_range(149) != 0);
            fault_clr = ($urandom_range(9) == 0);
            @(negedge HCLK);
        end

        mchk = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
